// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing front-end: opcode map, FSM states
// and a helper that flags the single illegal opcode.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD      = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB      = 4'h1;
  localparam logic [OP_W-1:0] OP_ACCU_SUM = 4'h2;
  localparam logic [OP_W-1:0] OP_AND      = 4'h3;
  localparam logic [OP_W-1:0] OP_OR       = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR      = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT      = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL      = 4'h7;
  localparam logic [OP_W-1:0] OP_SHR      = 4'h8;
  localparam logic [OP_W-1:0] OP_SRA      = 4'h9;
  localparam logic [OP_W-1:0] OP_SLT      = 4'hA;
  localparam logic [OP_W-1:0] OP_SLTU     = 4'hB;
  localparam logic [OP_W-1:0] OP_MUL      = 4'hC;
  localparam logic [OP_W-1:0] OP_PASS     = 4'hD;
  localparam logic [OP_W-1:0] OP_SEL_SUM  = 4'hE;
  localparam logic [OP_W-1:0] OP_ILLEGAL  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the "last served" register lives in the parent
// so the grant here is purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitration and sequencing front-end for a shared combinational ALU:
// accept one request, drive registered operands, capture result, return it.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_op,
  input  logic          req0_sel,
  input  logic [DW-1:0] req0_in1,
  input  logic [DW-1:0] req0_in2,
  input  logic [DW-1:0] req0_in3,
  input  logic [DW-1:0] req0_in4,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_op,
  input  logic          req1_sel,
  input  logic [DW-1:0] req1_in1,
  input  logic [DW-1:0] req1_in2,
  input  logic [DW-1:0] req1_in3,
  input  logic [DW-1:0] req1_in4,

  output logic [3:0]    alu_op,
  output logic          alu_sel,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [DW-1:0] alu_in3,
  output logic [DW-1:0] alu_in4,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,

  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_out,
  output logic          rsp_zero,
  output logic          rsp_err,

  output logic          busy
);

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic       owner;
  logic       err;
  logic [1:0] grant;
  logic       win;
  logic       rsp_fire;
  logic       can_accept;
  logic       accept;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign win = grant[1];

  // A new op may enter when idle, or in RESP on the very cycle the pending
  // result is taken, which gives the two-cycle back-to-back path.
  always_comb begin
    state_nxt  = state;
    rsp_fire   = 1'b0;
    can_accept = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        can_accept = !rst;
        accept     = can_accept && (grant != 2'b00);
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_fire   = owner ? rsp1_ready : rsp0_ready;
        can_accept = rsp_fire && !rst;
        accept     = can_accept && (grant != 2'b00);
        if (rsp_fire) state_nxt = accept ? EXEC : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req0_ready = grant[0] && can_accept;
  assign req1_ready = grant[1] && can_accept;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last  <= win;
        owner <= win;
        err   <= is_illegal(win ? req1_op : req0_op);
      end
    end
  end

  // Operand registers only change on accept so the ALU inputs stay steady
  // for the whole EXEC cycle and afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op  <= '0;
      alu_sel <= 1'b0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_in3 <= '0;
      alu_in4 <= '0;
    end else if (accept) begin
      alu_op  <= win ? req1_op  : req0_op;
      alu_sel <= win ? req1_sel : req0_sel;
      alu_in1 <= win ? req1_in1 : req0_in1;
      alu_in2 <= win ? req1_in2 : req0_in2;
      alu_in3 <= win ? req1_in3 : req0_in3;
      alu_in4 <= win ? req1_in4 : req0_in4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_out  <= alu_out;
      rsp_zero <= alu_zero;
      rsp_err  <= err;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the sharing front-end.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]    req0_op, req1_op;
  logic          req0_sel, req1_sel;
  logic [DW-1:0] req0_in1, req0_in2, req0_in3, req0_in4;
  logic [DW-1:0] req1_in1, req1_in2, req1_in3, req1_in4;
  logic [3:0]    alu_op;
  logic          alu_sel;
  logic [DW-1:0] alu_in1, alu_in2, alu_in3, alu_in4, alu_out;
  logic          alu_zero;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_out;
  logic          rsp_zero, rsp_err, busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_sel(req0_sel),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_in3(req0_in3), .req0_in4(req0_in4),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_sel(req1_sel),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_in3(req1_in3), .req1_in4(req1_in4),
    .alu_op(alu_op), .alu_sel(alu_sel),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3), .alu_in4(alu_in4),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in for the external ALU; 0xF falls to the default and yields 0.
  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic sel,
      input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [DW-1:0] c, input logic [DW-1:0] d);
    case (op)
      OP_ADD:      return a + b;
      OP_SUB:      return a - b;
      OP_ACCU_SUM: return a + b + c + d;
      OP_AND:      return a & b;
      OP_OR:       return a | b;
      OP_XOR:      return a ^ b;
      OP_NOT:      return ~a;
      OP_SHL:      return a << b[4:0];
      OP_SHR:      return a >> b[4:0];
      OP_SRA:      return DW'($signed(a) >>> b[4:0]);
      OP_SLT:      return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:     return {{(DW-1){1'b0}}, a < b};
      OP_MUL:      return a * b;
      OP_PASS:     return a;
      OP_SEL_SUM:  return sel ? (a + b) : (c + d);
      default:     return '0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_op, alu_sel, alu_in1, alu_in2, alu_in3, alu_in4);
  assign alu_zero = (alu_out == '0);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic v, input logic [3:0] op,
      input logic sel, input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [DW-1:0] c, input logic [DW-1:0] d);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_sel = sel;
      req0_in1 = a; req0_in2 = b; req0_in3 = c; req0_in4 = d;
    end else begin
      req1_valid = v; req1_op = op; req1_sel = sel;
      req1_in1 = a; req1_in2 = b; req1_in3 = c; req1_in4 = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Transaction model: at most one op in flight; its result is offered two
  // cycles after acceptance and retired when its owner takes it.
  logic          m_has;
  int            m_age;
  int            m_owner;
  int            m_last;
  logic [DW-1:0] m_res;
  logic          m_zero, m_err;
  logic [3:0]    m_op;
  logic          m_sel;
  logic [DW-1:0] m_in [4];

  task automatic modelReset();
    m_has = 1'b0; m_age = 0; m_owner = 0; m_last = 1;
    m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_op = '0; m_sel = 1'b0;
    for (int i = 0; i < 4; i++) m_in[i] = '0;
  endtask

  initial modelReset();

  always @(negedge clk) begin
    logic present, fire, can;
    int   winner;
    if (rst) begin
      checkOutput("rst_rsp0_valid", rsp0_valid, 0);
      checkOutput("rst_rsp1_valid", rsp1_valid, 0);
      checkOutput("rst_req0_ready", req0_ready, 0);
      checkOutput("rst_req1_ready", req1_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_alu_op", alu_op, 0);
      checkOutput("rst_alu_in1", alu_in1, 0);
      checkOutput("rst_rsp_out", rsp_out, 0);
      checkOutput("rst_rsp_flags", {rsp_zero, rsp_err}, 0);
      modelReset();
    end else begin
      present = m_has && (m_age >= 2);
      fire    = present && ((m_owner == 1) ? rsp1_ready : rsp0_ready);
      can     = !m_has || fire;
      if (req0_valid && req1_valid) winner = 1 - m_last;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
      else                          winner = -1;

      checkOutput("cyc_req0_ready", req0_ready, can && winner == 0);
      checkOutput("cyc_req1_ready", req1_ready, can && winner == 1);
      checkOutput("cyc_rsp0_valid", rsp0_valid, present && m_owner == 0);
      checkOutput("cyc_rsp1_valid", rsp1_valid, present && m_owner == 1);
      checkOutput("cyc_busy", busy, m_has);
      checkOutput("cyc_alu_ctl", {alu_op, alu_sel}, {m_op, m_sel});
      checkOutput("cyc_alu_in12", {alu_in1, alu_in2}, {m_in[0], m_in[1]});
      checkOutput("cyc_alu_in34", {alu_in3, alu_in4}, {m_in[2], m_in[3]});
      if (present) begin
        checkOutput("cyc_rsp_out", rsp_out, m_res);
        checkOutput("cyc_rsp_flags", {rsp_zero, rsp_err}, {m_zero, m_err});
      end

      if (fire) m_has = 1'b0;
      if (can && winner >= 0) begin
        m_has   = 1'b1;
        m_age   = 0;
        m_owner = winner;
        m_last  = winner;
        if (winner == 0) begin
          m_op = req0_op; m_sel = req0_sel;
          m_in[0] = req0_in1; m_in[1] = req0_in2; m_in[2] = req0_in3; m_in[3] = req0_in4;
        end else begin
          m_op = req1_op; m_sel = req1_sel;
          m_in[0] = req1_in1; m_in[1] = req1_in2; m_in[2] = req1_in3; m_in[3] = req1_in4;
        end
        m_res  = alu_fn(m_op, m_sel, m_in[0], m_in[1], m_in[2], m_in[3]);
        m_zero = (m_res == '0);
        m_err  = (m_op == 4'hF);
      end
      if (m_has) m_age++;
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_out", rsp_out, 0);
    tick();
    tick();
    rst = 1'b0;

    // Single add on port 0.
    applyStimulus(0, 1, OP_ADD, 0, 5, 7, 0, 0);
    rsp0_ready = 1'b1;
    #1;
    checkOutput("add_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("add_alu_in1", alu_in1, 5);
    checkOutput("add_alu_in2", alu_in2, 7);
    tick();
    checkOutput("add_rsp0_valid", rsp0_valid, 1);
    checkOutput("add_rsp_out", rsp_out, 12);
    checkOutput("add_flags", {rsp_zero, rsp_err}, 2'b00);
    tick();

    // Both valid right after reset: port 0 first, then port 1.
    doReset();
    applyStimulus(0, 1, OP_SUB, 0, 3, 3, 0, 0);
    applyStimulus(1, 1, OP_OR, 0, 32'hF0, 32'h0F, 0, 0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    checkOutput("tie_req0_ready", req0_ready, 1);
    checkOutput("tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("tie_exec_rsp1_valid", rsp1_valid, 0);
    tick();
    checkOutput("tie_rsp0_valid", rsp0_valid, 1);
    checkOutput("tie_rsp1_quiet", rsp1_valid, 0);
    checkOutput("tie_sub_out", rsp_out, 0);
    checkOutput("tie_sub_zero", rsp_zero, 1);
    checkOutput("tie_b2b_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    checkOutput("tie_exec_gap", {rsp0_valid, rsp1_valid, busy}, 3'b001);
    tick();
    checkOutput("tie_rsp1_valid", rsp1_valid, 1);
    checkOutput("tie_or_out", rsp_out, 32'hFF);
    tick();

    // Back-pressure on port 1 while port 0 waits.
    applyStimulus(1, 1, OP_ACCU_SUM, 0, 1, 2, 3, 4);
    rsp1_ready = 1'b0;
    #1;
    checkOutput("bp_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    applyStimulus(0, 1, OP_ADD, 0, 1, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_rsp1_valid", rsp1_valid, 1);
      checkOutput("bp_rsp_out", rsp_out, 10);
      checkOutput("bp_readys", {req0_ready, req1_ready}, 2'b00);
      checkOutput("bp_busy", busy, 1);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    checkOutput("bp_release_fire_accept", {rsp1_valid, req0_ready}, 2'b11);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();

    // Stream of three adds on port 0 with the response side always ready.
    rsp0_ready = 1'b1;
    applyStimulus(0, 1, OP_ADD, 0, 10, 1, 0, 0);
    #1;
    checkOutput("str_acc1", req0_ready, 1);
    tick();
    applyStimulus(0, 1, OP_ADD, 0, 20, 2, 0, 0);
    #1;
    checkOutput("str_exec1_ready", req0_ready, 0);
    tick();
    checkOutput("str_res1", rsp_out, 11);
    checkOutput("str_acc2", req0_ready, 1);
    tick();
    applyStimulus(0, 1, OP_ADD, 0, 30, 3, 0, 0);
    #1;
    checkOutput("str_exec2_ready", req0_ready, 0);
    tick();
    checkOutput("str_res2", rsp_out, 22);
    checkOutput("str_acc3", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("str_res3", rsp_out, 33);
    checkOutput("str_res3_valid", rsp0_valid, 1);
    tick();

    // Illegal opcode still executes and reports zero plus error.
    applyStimulus(0, 1, OP_ILLEGAL, 0, 9, 0, 0, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("ill_valid", rsp0_valid, 1);
    checkOutput("ill_out", rsp_out, 0);
    checkOutput("ill_flags", {rsp_zero, rsp_err}, 2'b11);
    tick();

    // Reset while in EXEC drops the operation.
    applyStimulus(0, 1, OP_ADD, 0, 2, 2, 0, 0);
    tick();
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstx_outputs", {rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready}, 0);
    checkOutput("rstx_alu_in1", alu_in1, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rstx_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
      tick();
    end
    applyStimulus(0, 1, OP_ADD, 0, 20, 22, 0, 0);
    #1;
    checkOutput("rstx_next_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("rstx_next_out", rsp_out, 42);
    tick();

    // Random traffic, including rare resets and illegal opcodes.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < 2; p++)
        applyStimulus(p, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 40),
                      $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, $urandom);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
